// File: rtl/ifetch_prefetch_if.sv
// Read/write bus between a fetch master and the on-chip RAM.
// ttype 0=READ 1=WRITE; tsize 0=BYTE 1=HALF 2=WORD.
interface master_bus_if;
   logic        ss;
   logic        bstart;
   logic [31:0] addr;
   logic        ttype;
   logic [1:0]  tsize;
   logic [31:0] wdata;
   logic        bdone;
   logic [31:0] rdata;

   modport master (
      output ss, bstart, addr, ttype, tsize, wdata,
      input  bdone, rdata
   );

   modport slave (
      input  ss, bstart, addr, ttype, tsize, wdata,
      output bdone, rdata
   );
endinterface

// File: rtl/ifetch_prefetch.sv
// Sequential instruction fetcher feeding a small prefetch FIFO.
// Define IFETCH_PERF_EN to add perf_fetched/perf_dropped counters.
module ifetch_prefetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   master_bus_if.master ibus,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_dropped
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [31:0]     pc;
   logic [31:0]     req_pc;
   logic            epoch;
   logic            req_epoch;
   logic [31:0]     mem_pc [DEPTH];
   logic [31:0]     mem_in [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic            done;
   logic            push;
   logic            pop;

   always_comb begin
      done      = (state == WAIT) && ibus.bdone;
      push      = done && (req_epoch == epoch) && !redirect;
      pop       = out_valid && out_ready && !redirect;
      count_nxt = count;
      state_nxt = state;
      if (redirect)
         count_nxt = '0;
      else
         count_nxt = count + CW'(push) - CW'(pop);
      unique case (state)
         IDLE: begin
            if (!redirect && count < CW'(DEPTH))
               state_nxt = REQ;
         end
         REQ: state_nxt = WAIT;
         WAIT: begin
            if (done) begin
               if (!redirect && count_nxt < CW'(DEPTH))
                  state_nxt = REQ;
               else
                  state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ibus.ss     = (state != IDLE);
      ibus.bstart = (state == REQ);
      ibus.addr   = (state == REQ) ? pc : req_pc;
      ibus.ttype  = 1'b0;
      ibus.tsize  = 2'd2;
      ibus.wdata  = '0;
      out_valid   = (count != '0);
      out_pc      = out_valid ? mem_pc[rd_ptr] : '0;
      out_instr   = out_valid ? mem_in[rd_ptr] : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         req_pc    <= '0;
         epoch     <= 1'b0;
         req_epoch <= 1'b0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (state == REQ)
            req_pc <= pc;
         // Pin the in-flight tag to the old epoch so a held
         // redirect can never toggle it back into a match.
         if (redirect || state == REQ)
            req_epoch <= epoch;
         if (redirect) begin
            pc     <= redirect_pc & ~32'd3;
            epoch  <= ~epoch;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (state == REQ)
               pc <= pc + 32'd4;
            if (push)
               wr_ptr <= wr_ptr + 1'b1;
            if (pop)
               rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wr_ptr] <= req_pc;
         mem_in[wr_ptr] <= ibus.rdata;
      end
   end

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else if (done) begin
         perf_fetched <= perf_fetched + 32'd1;
         if (req_epoch != epoch)
            perf_dropped <= perf_dropped + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: RAM model with variable latency and
// an in-order fetch-stream reference model.
module tb_ifetch_prefetch;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        v2;
   logic [31:0] pc2;
   logic [31:0] in2;
   int          checks = 0;
   int          passed = 0;
   int          lat = 1;
   logic        pend = 1'b0;
   int          cnt = 0;
   logic [31:0] ra = '0;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_dropped;
   logic [31:0] pf2;
   logic [31:0] pd2;
`endif

   master_bus_if bus ();
   master_bus_if bus2 ();

   always #5 clk = ~clk;

   ifetch_prefetch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ibus        (bus.master),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr)
`ifdef IFETCH_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_dropped(perf_dropped)
`endif
   );

   ifetch_prefetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
      .clk         (clk),
      .rst_n       (rst_n),
      .ibus        (bus2.master),
      .redirect    (1'b0),
      .redirect_pc (32'h0),
      .out_valid   (v2),
      .out_ready   (1'b1),
      .out_pc      (pc2),
      .out_instr   (in2)
`ifdef IFETCH_PERF_EN
      ,
      .perf_fetched(pf2),
      .perf_dropped(pd2)
`endif
   );

   function automatic logic [31:0] f(input logic [31:0] a);
      return (a << 5) + 32'h13;
   endfunction

   // RAM: bdone arrives lat cycles after bstart
   always @(posedge clk) begin
      bus.bdone <= 1'b0;
      if (pend) begin
         if (cnt <= 1) begin
            bus.bdone <= 1'b1;
            bus.rdata <= f(ra);
            pend      <= 1'b0;
         end else begin
            cnt <= cnt - 1;
         end
      end else if (bus.bstart) begin
         if (lat <= 1) begin
            bus.bdone <= 1'b1;
            bus.rdata <= f(bus.addr);
         end else begin
            pend <= 1'b1;
            cnt  <= lat - 1;
            ra   <= bus.addr;
         end
      end
   end

   always @(posedge clk) begin
      bus2.bdone <= bus2.bstart;
      bus2.rdata <= f(bus2.addr);
   end

   task automatic do_reset();
      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      out_ready   = 1'b0;
      lat         = 1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      checks += 7;
      if (bus.ss !== 1'b0)
         $display("FAIL rst_ss got %b want 0", bus.ss);
      else passed++;
      if (bus.bstart !== 1'b0)
         $display("FAIL rst_bstart got %b want 0", bus.bstart);
      else passed++;
      if (bus.addr !== 32'h0)
         $display("FAIL rst_addr got %h want 0", bus.addr);
      else passed++;
      if (out_valid !== 1'b0)
         $display("FAIL rst_valid got %b want 0", out_valid);
      else passed++;
      if (out_pc !== 32'h0)
         $display("FAIL rst_pc got %h want 0", out_pc);
      else passed++;
      if (out_instr !== 32'h0)
         $display("FAIL rst_instr got %h want 0", out_instr);
      else passed++;
      if (bus2.addr !== 32'h0)
         $display("FAIL rst_addr2 got %h want 0", bus2.addr);
      else passed++;
   endtask

   task automatic test_sequential();
      int first;
      int np;
      int last;
      logic [31:0] e;
      do_reset();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      first = -1;
      np    = 0;
      last  = 0;
      for (int n = 1; n <= 40 && np < 4; n++) begin
         @(negedge clk);
         if (out_valid && first < 0) first = n;
         if (out_valid && out_ready) begin
            e = 32'(np * 4);
            checks += 2;
            if (out_pc !== e)
               $display("FAIL seq_pc got %h want %h", out_pc, e);
            else passed++;
            if (out_instr !== f(e))
               $display("FAIL seq_instr got %h want %h",
                        out_instr, f(e));
            else passed++;
            if (np > 0) begin
               checks++;
               if (n - last !== 2)
                  $display("FAIL seq_gap got %0d want 2", n - last);
               else passed++;
            end
            last = n;
            np++;
         end
      end
      checks += 2;
      if (first !== 3)
         $display("FAIL seq_latency got %0d want 3", first);
      else passed++;
      if (np !== 4)
         $display("FAIL seq_timeout got %0d pops want 4", np);
      else passed++;
   endtask

   task automatic test_stall();
      int nb;
      int np;
      logic [31:0] e;
      do_reset();
      rst_n = 1'b1;
      nb    = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.bstart) nb++;
      end
      checks += 3;
      if (nb !== 4)
         $display("FAIL stall_fetches got %0d want 4", nb);
      else passed++;
      if (bus.ss !== 1'b0)
         $display("FAIL stall_ss got %b want 0", bus.ss);
      else passed++;
      if (out_valid !== 1'b1)
         $display("FAIL stall_valid got %b want 1", out_valid);
      else passed++;
      out_ready = 1'b1;
      np = 0;
      for (int n = 0; n < 40 && np < 6; n++) begin
         if (out_valid) begin
            e = 32'(np * 4);
            checks++;
            if (out_pc !== e || out_instr !== f(e))
               $display("FAIL stall_drain got %h/%h want %h/%h",
                        out_pc, out_instr, e, f(e));
            else passed++;
            np++;
         end
         @(negedge clk);
      end
      checks++;
      if (np !== 6)
         $display("FAIL stall_timeout got %0d pops want 6", np);
      else passed++;
   endtask

   task automatic test_redirect_wait();
      int np;
      int k;
      logic [31:0] e;
      do_reset();
      lat   = 3;
      rst_n = 1'b1;
      out_ready = 1'b1;
      k = 0;
      while (!(bus.ss && !bus.bstart) && k < 20) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 20)
         $display("FAIL rdw_wait_timeout got %0d want <20", k);
      else passed++;
      redirect    = 1'b1;
      redirect_pc = 32'h103;
      @(negedge clk);
      redirect = 1'b0;
      np = 0;
      for (int n = 0; n < 60 && np < 2; n++) begin
         if (out_valid) begin
            e = 32'h100 + 32'(np * 4);
            checks++;
            if (out_pc !== e || out_instr !== f(e))
               $display("FAIL rdw_pop got %h/%h want %h/%h",
                        out_pc, out_instr, e, f(e));
            else passed++;
            np++;
         end
         @(negedge clk);
      end
      checks++;
      if (np !== 2)
         $display("FAIL rdw_timeout got %0d pops want 2", np);
      else passed++;
`ifdef IFETCH_PERF_EN
      checks++;
      if (perf_dropped !== 32'd1)
         $display("FAIL rdw_perf_dropped got %0d want 1",
                  perf_dropped);
      else passed++;
`endif
   endtask

   task automatic test_redirect_pop_bdone();
      int k;
      int np;
      do_reset();
      rst_n = 1'b1;
      k = 0;
      while (!(out_valid && bus.bdone) && k < 30) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 30)
         $display("FAIL rpb_setup_timeout got %0d want <30", k);
      else passed++;
      out_ready   = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      @(negedge clk);
      redirect = 1'b0;
      checks++;
      if (out_valid !== 1'b0)
         $display("FAIL rpb_valid got %b want 0", out_valid);
      else passed++;
      np = 0;
      for (int n = 0; n < 30 && np < 1; n++) begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (out_pc !== 32'h200 || out_instr !== f(32'h200))
               $display("FAIL rpb_pop got %h/%h want %h/%h",
                        out_pc, out_instr, 32'h200, f(32'h200));
            else passed++;
            np++;
         end
      end
      checks++;
      if (np !== 1)
         $display("FAIL rpb_timeout got %0d pops want 1", np);
      else passed++;
   endtask

   task automatic test_reset_mid_wait();
      int k;
      int np;
      do_reset();
      lat   = 2;
      rst_n = 1'b1;
      out_ready = 1'b1;
      k = 0;
      while (!(bus.ss && !bus.bstart) && k < 20) begin
         @(negedge clk);
         k++;
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks += 3;
      if (bus.ss !== 1'b0)
         $display("FAIL rmw_ss got %b want 0", bus.ss);
      else passed++;
      if (out_valid !== 1'b0)
         $display("FAIL rmw_valid got %b want 0", out_valid);
      else passed++;
      if (k >= 20)
         $display("FAIL rmw_wait_timeout got %0d want <20", k);
      else passed++;
      rst_n = 1'b1;
      lat   = 1;
      np = 0;
      for (int n = 0; n < 30 && np < 2; n++) begin
         @(negedge clk);
         if (out_valid) begin
            checks++;
            if (out_pc !== 32'(np * 4) || out_instr !== f(32'(np * 4)))
               $display("FAIL rmw_pop got %h/%h want %h/%h",
                        out_pc, out_instr, 32'(np * 4),
                        f(32'(np * 4)));
            else passed++;
            np++;
         end
      end
      checks++;
      if (np !== 2)
         $display("FAIL rmw_timeout got %0d pops want 2", np);
      else passed++;
   endtask

   task automatic test_wrap();
      logic [31:0] want [3];
      int na;
      want[0] = 32'hFFFF_FFF8;
      want[1] = 32'hFFFF_FFFC;
      want[2] = 32'h0000_0000;
      do_reset();
      rst_n = 1'b1;
      na = 0;
      for (int n = 0; n < 30 && na < 3; n++) begin
         @(negedge clk);
         if (bus2.bstart) begin
            checks++;
            if (bus2.addr !== want[na])
               $display("FAIL wrap_addr got %h want %h",
                        bus2.addr, want[na]);
            else passed++;
            na++;
         end
      end
      checks++;
      if (na !== 3)
         $display("FAIL wrap_timeout got %0d want 3", na);
      else passed++;
   endtask

   task automatic test_random();
      logic [31:0] e;
      int np;
      do_reset();
      rst_n = 1'b1;
      e  = 32'h0;
      np = 0;
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         redirect    = ($urandom % 16) == 0;
         redirect_pc = $urandom;
         out_ready   = ($urandom % 4) != 0;
         lat         = $urandom_range(1, 3);
         if (redirect) begin
            e = redirect_pc & ~32'd3;
         end else if (out_valid && out_ready) begin
            checks++;
            if (out_pc !== e || out_instr !== f(e))
               $display("FAIL rand_pop got %h/%h want %h/%h",
                        out_pc, out_instr, e, f(e));
            else passed++;
            e = e + 32'd4;
            np++;
         end
      end
      redirect  = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (np < 100)
         $display("FAIL rand_progress got %0d pops want >=100", np);
      else passed++;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_wait();
      test_redirect_pop_bdone();
      test_reset_mid_wait();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
